// File: rtl/multicore_debug_break_ctrl_if.sv
// Bundles the core-side and host-side signals of the cross-trigger break
// controller. The controller connects through the slave modport. The
// debug-module or bench side connects through the master modport.
interface multicore_debug_break_ctrl_if #(
  parameter int NUM_CORES = 4
);
  logic [NUM_CORES-1:0] cfg_xtrig_en;
  logic [NUM_CORES-1:0] core_dbrk_hit;
  logic [NUM_CORES-1:0] host_break;
  logic                 host_resume;
  logic                 err_clr;
  logic [NUM_CORES-1:0] core_debugack;
  logic [NUM_CORES-1:0] core_debugreq;
  logic                 halted_all;
  logic [NUM_CORES-1:0] break_src;
  logic [NUM_CORES-1:0] stuck_mask;
  logic                 timeout_err;
  logic                 busy;

  modport master (
    output cfg_xtrig_en, core_dbrk_hit, host_break, host_resume, err_clr,
           core_debugack,
    input  core_debugreq, halted_all, break_src, stuck_mask, timeout_err, busy
  );

  modport slave (
    input  cfg_xtrig_en, core_dbrk_hit, host_break, host_resume, err_clr,
           core_debugack,
    output core_debugreq, halted_all, break_src, stuck_mask, timeout_err, busy
  );
endinterface

// File: rtl/multicore_debug_break_ctrl.sv
// Cross-trigger break controller. A breakpoint or host break on any
// participating core halts every participating core. All of them are
// released together on one host resume command.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no break in progress, debug requests low
// HALT_REQ | requesting debug on mask_q, waiting for all acks (timed)
// HALTED   | cores held in debug, waiting for host_resume
// RESUME   | requests dropped, waiting for all acks to fall (timed)
module multicore_debug_break_ctrl #(
  parameter int NUM_CORES   = 4,
  parameter int TMO_W       = 8,
  parameter int ACK_TIMEOUT = 200
) (
  input  logic clk,
  input  logic reset,
  multicore_debug_break_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HALT_REQ = 2'd1,
    HALTED   = 2'd2,
    RESUME   = 2'd3
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = {TMO_W{1'b1}};

  state_t               state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_d;
  logic [NUM_CORES-1:0] req_q, req_d;
  logic                 halted_q, halted_d;
  logic [NUM_CORES-1:0] src_q, src_d;
  logic [NUM_CORES-1:0] stuck_q, stuck_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic [NUM_CORES-1:0] trig;
  logic [NUM_CORES-1:0] ack_m;
  logic                 all_ack;
  logic                 no_ack;
  logic [TMO_W-1:0]     tmo_inc;

  // Qualified triggers and the acks seen through the captured mask.
  always_comb begin
    trig    = (bus.core_dbrk_hit | bus.host_break) & bus.cfg_xtrig_en;
    ack_m   = bus.core_debugack & mask_q;
    all_ack = (ack_m == mask_q);
    no_ack  = (ack_m == '0);
    tmo_inc = (tmo_cnt == TMO_SAT) ? tmo_cnt : tmo_cnt + 1'b1;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    tmo_cnt_d = tmo_cnt;
    req_d     = req_q;
    halted_d  = halted_q;
    src_d     = src_q;
    stuck_d   = stuck_q;
    err_d     = err_q;

    // A clear is applied first, so a timeout later in this block overrides it.
    if (bus.err_clr) begin
      err_d   = 1'b0;
      stuck_d = '0;
    end

    case (state_q)
      IDLE: begin
        req_d    = '0;
        halted_d = 1'b0;
        if (trig != '0) begin
          mask_d    = bus.cfg_xtrig_en;
          src_d     = trig;
          tmo_cnt_d = '0;
          req_d     = bus.cfg_xtrig_en;
          state_d   = HALT_REQ;
        end
      end

      HALT_REQ: begin
        req_d = mask_q;
        src_d = src_q | (trig & mask_q);
        if (all_ack) begin
          halted_d  = 1'b1;
          tmo_cnt_d = '0;
          state_d   = HALTED;
        end else if (tmo_cnt == TMO_LAST) begin
          err_d     = 1'b1;
          stuck_d   = mask_q & ~bus.core_debugack;
          halted_d  = 1'b0;
          tmo_cnt_d = '0;
          state_d   = HALTED;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end

      HALTED: begin
        req_d    = mask_q;
        halted_d = all_ack;
        src_d    = src_q | (trig & mask_q);
        if (bus.host_resume) begin
          req_d     = '0;
          halted_d  = 1'b0;
          tmo_cnt_d = '0;
          state_d   = RESUME;
        end
      end

      RESUME: begin
        req_d    = '0;
        halted_d = 1'b0;
        if (no_ack) begin
          src_d     = '0;
          tmo_cnt_d = '0;
          state_d   = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          err_d     = 1'b1;
          stuck_d   = mask_q & bus.core_debugack;
          tmo_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end

      default: begin
        req_d     = '0;
        halted_d  = 1'b0;
        tmo_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs. Reset drops every request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      tmo_cnt  <= '0;
      req_q    <= '0;
      halted_q <= 1'b0;
      src_q    <= '0;
      stuck_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      tmo_cnt  <= tmo_cnt_d;
      req_q    <= req_d;
      halted_q <= halted_d;
      src_q    <= src_d;
      stuck_q  <= stuck_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.core_debugreq = req_q;
  assign bus.halted_all    = halted_q;
  assign bus.break_src     = src_q;
  assign bus.stuck_mask    = stuck_q;
  assign bus.timeout_err   = err_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_multicore_debug_break_ctrl.sv
// Directed bench for the cross-trigger break controller.
module tb_multicore_debug_break_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  multicore_debug_break_ctrl_if #(.NUM_CORES(4)) bus ();

  multicore_debug_break_ctrl #(
    .NUM_CORES(4), .TMO_W(8), .ACK_TIMEOUT(200)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.cfg_xtrig_en  = 4'b0000;
    bus.core_dbrk_hit = 4'b0000;
    bus.host_break    = 4'b0000;
    bus.host_resume   = 1'b0;
    bus.err_clr       = 1'b0;
    bus.core_debugack = 4'b0000;
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (bus.core_debugreq !== 4'b0000) begin n_fail++; $display("FAIL reset_req got %b want 0000", bus.core_debugreq); end
    n_cmp++; if (bus.halted_all !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", bus.halted_all); end
    n_cmp++; if (bus.break_src !== 4'b0000) begin n_fail++; $display("FAIL reset_src got %b want 0000", bus.break_src); end
    n_cmp++; if (bus.stuck_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_stuck got %b want 0000", bus.stuck_mask); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.timeout_err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    bus.cfg_xtrig_en  = 4'b1111;
    tick(1);
    bus.core_dbrk_hit = 4'b0100;
    tick(1);
    bus.core_dbrk_hit = 4'b0000;
    n_cmp++; if (bus.core_debugreq !== 4'b1111) begin n_fail++; $display("FAIL basic_req got %b want 1111", bus.core_debugreq); end
    n_cmp++; if (bus.break_src !== 4'b0100) begin n_fail++; $display("FAIL basic_src got %b want 0100", bus.break_src); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", bus.busy); end
    tick(3);
    n_cmp++; if (bus.halted_all !== 1'b0) begin n_fail++; $display("FAIL basic_not_halted got %b want 0", bus.halted_all); end
    bus.core_debugack = 4'b1111;
    tick(1);
    n_cmp++; if (bus.halted_all !== 1'b1) begin n_fail++; $display("FAIL basic_halted got %b want 1", bus.halted_all); end
    bus.host_resume = 1'b1;
    tick(1);
    bus.host_resume = 1'b0;
    n_cmp++; if (bus.core_debugreq !== 4'b0000) begin n_fail++; $display("FAIL basic_resume_req got %b want 0000", bus.core_debugreq); end
    n_cmp++; if (bus.halted_all !== 1'b0) begin n_fail++; $display("FAIL basic_resume_halted got %b want 0", bus.halted_all); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_resume_busy got %b want 1", bus.busy); end
    bus.core_debugack = 4'b0000;
    tick(1);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.break_src !== 4'b0000) begin n_fail++; $display("FAIL basic_idle_src got %b want 0000", bus.break_src); end
    tick(2);
  endtask

  task automatic test_mask();
    bus.cfg_xtrig_en  = 4'b0000;
    bus.core_dbrk_hit = 4'b1111;
    tick(2);
    bus.core_dbrk_hit = 4'b0000;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mask_zero_busy got %b want 0", bus.busy); end
    bus.cfg_xtrig_en  = 4'b0101;
    bus.core_dbrk_hit = 4'b0010;
    tick(1);
    bus.core_dbrk_hit = 4'b0000;
    tick(1);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mask_off_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.core_debugreq !== 4'b0000) begin n_fail++; $display("FAIL mask_off_req got %b want 0000", bus.core_debugreq); end
    bus.host_break = 4'b0100;
    tick(1);
    bus.host_break = 4'b0000;
    n_cmp++; if (bus.core_debugreq !== 4'b0101) begin n_fail++; $display("FAIL mask_req got %b want 0101", bus.core_debugreq); end
    n_cmp++; if (bus.break_src !== 4'b0100) begin n_fail++; $display("FAIL mask_src got %b want 0100", bus.break_src); end
    bus.core_debugack = 4'b1010;
    tick(2);
    n_cmp++; if (bus.halted_all !== 1'b0) begin n_fail++; $display("FAIL mask_foreign_ack got %b want 0", bus.halted_all); end
    bus.core_debugack = 4'b0101;
    tick(1);
    n_cmp++; if (bus.halted_all !== 1'b1) begin n_fail++; $display("FAIL mask_halted got %b want 1", bus.halted_all); end
    bus.host_resume = 1'b1;
    tick(1);
    bus.host_resume = 1'b0;
    bus.core_debugack = 4'b1010;
    tick(1);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mask_resume_busy got %b want 0", bus.busy); end
    bus.core_debugack = 4'b0000;
    tick(2);
  endtask

  task automatic test_join_and_ignore();
    bus.cfg_xtrig_en  = 4'b1111;
    bus.core_dbrk_hit = 4'b0100;
    tick(1);
    bus.core_dbrk_hit = 4'b0000;
    bus.cfg_xtrig_en  = 4'b0001;
    tick(2);
    bus.core_dbrk_hit = 4'b0001;
    tick(1);
    bus.core_dbrk_hit = 4'b0000;
    n_cmp++; if (bus.break_src !== 4'b0101) begin n_fail++; $display("FAIL join_src got %b want 0101", bus.break_src); end
    n_cmp++; if (bus.core_debugreq !== 4'b1111) begin n_fail++; $display("FAIL join_cfg_change_req got %b want 1111", bus.core_debugreq); end
    bus.host_resume = 1'b1;
    tick(1);
    bus.host_resume = 1'b0;
    tick(1);
    n_cmp++; if (bus.core_debugreq !== 4'b1111) begin n_fail++; $display("FAIL early_resume_req got %b want 1111", bus.core_debugreq); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL early_resume_busy got %b want 1", bus.busy); end
    bus.core_debugack = 4'b1111;
    tick(1);
    n_cmp++; if (bus.halted_all !== 1'b1) begin n_fail++; $display("FAIL join_halted got %b want 1", bus.halted_all); end
    bus.host_resume = 1'b1;
    tick(1);
    bus.host_resume = 1'b0;
    bus.cfg_xtrig_en  = 4'b1111;
    bus.core_dbrk_hit = 4'b0010;
    tick(1);
    bus.core_dbrk_hit = 4'b0000;
    n_cmp++; if (bus.break_src !== 4'b0101) begin n_fail++; $display("FAIL resume_trig_src got %b want 0101", bus.break_src); end
    n_cmp++; if (bus.core_debugreq !== 4'b0000) begin n_fail++; $display("FAIL resume_trig_req got %b want 0000", bus.core_debugreq); end
    bus.core_debugack = 4'b0000;
    tick(1);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL resume_trig_idle got %b want 0", bus.busy); end
    tick(1);
    n_cmp++; if (bus.core_debugreq !== 4'b0000) begin n_fail++; $display("FAIL resume_trig_no_reentry got %b want 0000", bus.core_debugreq); end
    tick(2);
  endtask

  task automatic test_timeout();
    bus.cfg_xtrig_en  = 4'b1111;
    bus.core_debugack = 4'b0111;
    bus.core_dbrk_hit = 4'b0001;
    tick(1);
    bus.core_dbrk_hit = 4'b0000;
    tick(199);
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %b want 0", bus.timeout_err); end
    tick(1);
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", bus.timeout_err); end
    n_cmp++; if (bus.stuck_mask !== 4'b1000) begin n_fail++; $display("FAIL tmo_stuck got %b want 1000", bus.stuck_mask); end
    n_cmp++; if (bus.halted_all !== 1'b0) begin n_fail++; $display("FAIL tmo_halted got %b want 0", bus.halted_all); end
    tick(1);
    n_cmp++; if (bus.halted_all !== 1'b0) begin n_fail++; $display("FAIL tmo_halted_hold got %b want 0", bus.halted_all); end
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clr_err got %b want 0", bus.timeout_err); end
    n_cmp++; if (bus.stuck_mask !== 4'b0000) begin n_fail++; $display("FAIL tmo_clr_stuck got %b want 0000", bus.stuck_mask); end
    // Resume with acks stuck high while err_clr is held: the set must win.
    bus.host_resume = 1'b1;
    tick(1);
    bus.host_resume = 1'b0;
    bus.err_clr = 1'b1;
    tick(199);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rtmo_busy got %b want 1", bus.busy); end
    tick(1);
    bus.err_clr = 1'b0;
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL rtmo_err_set_wins got %b want 1", bus.timeout_err); end
    n_cmp++; if (bus.stuck_mask !== 4'b0111) begin n_fail++; $display("FAIL rtmo_stuck got %b want 0111", bus.stuck_mask); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rtmo_idle got %b want 0", bus.busy); end
    bus.core_debugack = 4'b0000;
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rtmo_clr got %b want 0", bus.timeout_err); end
    tick(2);
  endtask

  task automatic test_async_reset();
    bus.cfg_xtrig_en  = 4'b1111;
    bus.host_break    = 4'b0010;
    tick(1);
    bus.host_break    = 4'b0000;
    bus.core_debugack = 4'b1111;
    tick(2);
    n_cmp++; if (bus.core_debugreq !== 4'b1111) begin n_fail++; $display("FAIL ar_pre_req got %b want 1111", bus.core_debugreq); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.core_debugreq !== 4'b0000) begin n_fail++; $display("FAIL ar_req got %b want 0000", bus.core_debugreq); end
    n_cmp++; if (bus.halted_all !== 1'b0) begin n_fail++; $display("FAIL ar_halted got %b want 0", bus.halted_all); end
    n_cmp++; if (bus.break_src !== 4'b0000) begin n_fail++; $display("FAIL ar_src got %b want 0000", bus.break_src); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %b want 0", bus.busy); end
    bus.core_debugack = 4'b0000;
    tick(2);
    reset = 1'b0;
    tick(1);
    bus.core_dbrk_hit = 4'b1000;
    tick(1);
    bus.core_dbrk_hit = 4'b0000;
    n_cmp++; if (bus.core_debugreq !== 4'b1111) begin n_fail++; $display("FAIL ar_restart_req got %b want 1111", bus.core_debugreq); end
    n_cmp++; if (bus.break_src !== 4'b1000) begin n_fail++; $display("FAIL ar_restart_src got %b want 1000", bus.break_src); end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_join_and_ignore();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
